coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
- Front-end stage that feeds the vending FSM's 2-bit coin input.
- Synchronises and debounces three raw coin-slot sensors, qualifies each coin and rejects ambiguous or inhibited coins.
- Detects jammed sensors and buffers accepted coins in a small FIFO.
- Presents queued coins downstream with a valid/ready handshake, using the vending coin encoding:
  - 2'b00 = 25
  - 2'b01 = 50
  - 2'b10 = 100
  - 2'b11 = no coin

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required to qualify a sensor pattern; legal range 2..255.
- JAM_CYCLES, 1280: cycles any sensor may stay high after qualification before jam is declared; must be > DEBOUNCE_CYCLES.
- FIFO_DEPTH, 4: accepted-coin queue depth; power of two, 2..16.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- sense_25  in  1  raw 25 sensor, asynchronous, active-high
- sense_50  in  1  raw 50 sensor, asynchronous, active-high
- sense_100  in  1  raw 100 sensor, asynchronous, active-high
- inhibit  in  1  when high, qualified coins are rejected rather than queued
- coin_out  out  2  FIFO head code; 2'b11 when coin_valid=0
- coin_valid  out  1  FIFO not empty
- coin_ready  in  1  downstream accepts head this cycle
- reject_pulse  out  1  one-cycle pulse per rejected coin
- jam  out  1  level; sensor stuck
- fifo_full  out  1  FIFO occupancy == FIFO_DEPTH

Behaviour:
- Reset values: coin_out=2'b11, coin_valid=0, reject_pulse=0, jam=0, fifo_full=0. FIFO is emptied, FSM goes to IDLE, synchronisers are cleared.
- Each sense_* passes through a 2-flop synchroniser. pat = synced {100,50,25}.
- FSM states: IDLE, QUAL, WAIT_REL, JAM.
  - IDLE: pat!=0 -> QUAL; latch pat; debounce counter = 1.
  - QUAL, pat == latched: counter increments. When counter reaches DEBOUNCE_CYCLES, a qualify event fires and the FSM goes to WAIT_REL.
  - QUAL, pat changes to nonzero: relatch pat, counter = 1.
  - QUAL, pat changes to 0: -> IDLE, no event (glitch).
  - Qualify event, pat one-hot, inhibit=0, push permitted: push code.
  - Qualify event, pat not one-hot (multiple sensors high): reject_pulse=1 for one cycle.
  - Qualify event, inhibit=1, or push not permitted: reject_pulse=1 for one cycle.
  - WAIT_REL: jam counter increments while pat!=0 and clears on pat==0. pat==0 -> IDLE. Counter reaching JAM_CYCLES -> JAM.
  - JAM: jam=1. Leaves to IDLE only after pat==0 for DEBOUNCE_CYCLES consecutive cycles; jam drops on that transition. Sensors are not qualified while in JAM.
- FIFO:
  - Pop occurs when coin_valid & coin_ready. coin_out/coin_valid are driven from registered FIFO state; a push is visible on coin_valid the cycle after the qualify event.
  - Push is permitted when not full, or when full with a pop in the same cycle. Occupancy is then unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter is $clog2(FIFO_DEPTH)+1 bits.
- Latency: a clean edge on a sensor reaches coin_valid in 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- reset mid-coin: FSM returns to IDLE and the FIFO is emptied. A sensor still held after reset is treated as a new coin (requalified).
- coin_ready while coin_valid=0 is ignored.

Optional Feature:
- Macro COIN_STATS_EN.
- Defined: adds outputs accepted_count[15:0] and rejected_count[15:0].
  - accepted_count increments on each push; rejected_count increments on each reject_pulse.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: no ports or logic for the counters; behaviour is otherwise identical.

Decomposition:
- Package coin_pkg holds:
  - localparams COIN_25=2'b00, COIN_50=2'b01, COIN_100=2'b10, COIN_NONE=2'b11
  - FSM state encodings IDLE/QUAL/WAIT_REL/JAM (2-bit)
- One sub-module coin_fifo: parameterised sync FIFO with push/pop/full/empty/head, instantiated once.

Test Plan (DEBOUNCE_CYCLES=4, JAM_CYCLES=16, FIFO_DEPTH=4):
- sense_50 high for 10 cycles, coin_ready=1 -> coin_out=2'b01 with coin_valid for exactly 1 cycle, 7 cycles after the rising edge; reject_pulse never asserts.
- sense_25 high for 3 cycles, then low -> no push, no reject; FSM returns to IDLE.
- sense_25 and sense_100 high together for 8 cycles -> one reject_pulse; FIFO stays empty.
- coin_ready=0, then five clean 100 coins -> first four queued (fifo_full=1), fifth gives reject_pulse. Raise coin_ready -> four 2'b10 pops on consecutive cycles, then coin_out=2'b11.
- sense_50 held 40 cycles -> one 50 coin queued; jam=1 at 2+4+16 cycles after the edge. Release sense_50 -> jam=0 4 cycles after the synced low; a following 25 coin is accepted normally.
- inhibit=1 during a 25 coin -> reject_pulse. With COIN_STATS_EN defined: rejected_count=1, accepted_count=0.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared definitions for the coin acceptor: vending coin encodings,
// front-end FSM state encoding and sensor-pattern helpers.
package coin_pkg;

  localparam logic [1:0] COIN_25   = 2'b00;
  localparam logic [1:0] COIN_50   = 2'b01;
  localparam logic [1:0] COIN_100  = 2'b10;
  localparam logic [1:0] COIN_NONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL     = 2'd1,
    WAIT_REL = 2'd2,
    JAM      = 2'd3
  } state_e;

  // Sensor pattern is {100, 50, 25}; anything not one-hot maps to no coin.
  function automatic logic [1:0] pat_to_code(input logic [2:0] pat);
    case (pat)
      3'b001:  return COIN_25;
      3'b010:  return COIN_50;
      3'b100:  return COIN_100;
      default: return COIN_NONE;
    endcase
  endfunction

  function automatic logic pat_is_one_hot(input logic [2:0] pat);
    return (pat == 3'b001) || (pat == 3'b010) || (pat == 3'b100);
  endfunction

endpackage

// File: rtl/coin_fifo.sv
// Small synchronous FIFO holding accepted coin codes. A push is taken when
// not full, or when full together with a pop (occupancy then unchanged).
// Pop on empty is ignored.
module coin_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next pointers, occupancy and storage contents.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; emptied on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observed when occupancy is non-zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronises and debounces the three coin
// sensors, qualifies or rejects each coin, detects jammed sensors and queues
// accepted coins for the vending FSM over a valid/ready interface.
// Optional macro COIN_STATS_EN adds saturating accepted/rejected counters.
//
// Handshake: coin_valid is high whenever the queue holds a coin and coin_out
// carries its code (2'b11 otherwise); the head is consumed on any cycle with
// coin_valid & coin_ready, and coin_ready is ignored while coin_valid is low.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 1280,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sense_25,
  input  logic        sense_50,
  input  logic        sense_100,
  input  logic        inhibit,
  output logic [1:0]  coin_out,
  output logic        coin_valid,
  input  logic        coin_ready,
  output logic        reject_pulse,
  output logic        jam,
  output logic        fifo_full
`ifdef COIN_STATS_EN
  ,
  output logic [15:0] accepted_count,
  output logic [15:0] rejected_count
`endif
);

  localparam int              JW      = $clog2(JAM_CYCLES + 1);
  localparam logic [7:0]      DEB_MAX = 8'(DEBOUNCE_CYCLES);
  localparam logic [JW-1:0]   JAM_MAX = JW'(JAM_CYCLES);

  logic [2:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]    pat;
  state_e        state_q, state_d;
  logic [2:0]    lat_q, lat_d;
  logic [7:0]    deb_q, deb_d;
  logic [JW-1:0] jcnt_q, jcnt_d, jcnt_inc;
  logic          reject_q, reject_d;
  logic          qual_evt, push, pop, push_ok;
  logic          fifo_empty;
  logic [1:0]    fifo_head;

  assign pat      = sync2_q;
  assign jcnt_inc = jcnt_q + JW'(1);

  // Two-flop synchroniser feeding the debouncer.
  always_comb begin
    sync1_d = {sense_100, sense_50, sense_25};
    sync2_d = sync1_q;
  end

  // Debounce/qualify/jam FSM next state. deb_q counts stable cycles while
  // qualifying and consecutive quiet cycles while jammed.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    deb_d    = deb_q;
    jcnt_d   = jcnt_q;
    qual_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (pat != 3'b000) begin
          state_d = QUAL;
          lat_d   = pat;
          deb_d   = 8'd1;
        end
      end
      QUAL: begin
        if (pat == 3'b000) begin
          state_d = IDLE;
        end else if (pat != lat_q) begin
          lat_d = pat;
          deb_d = 8'd1;
        end else if (deb_q == DEB_MAX) begin
          qual_evt = 1'b1;
          state_d  = WAIT_REL;
          jcnt_d   = JW'(1);
        end else begin
          deb_d = deb_q + 8'd1;
        end
      end
      WAIT_REL: begin
        if (pat == 3'b000) begin
          state_d = IDLE;
          jcnt_d  = '0;
        end else begin
          jcnt_d = jcnt_inc;
          if (jcnt_inc == JAM_MAX) begin
            state_d = JAM;
            deb_d   = 8'd0;
          end
        end
      end
      JAM: begin
        if (pat != 3'b000) begin
          deb_d = 8'd0;
        end else if (deb_q + 8'd1 == DEB_MAX) begin
          state_d = IDLE;
          deb_d   = 8'd0;
        end else begin
          deb_d = deb_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Accept/reject decision at the qualify event.
  always_comb begin
    pop      = coin_valid & coin_ready;
    push_ok  = ~fifo_full | pop;
    push     = qual_evt & pat_is_one_hot(lat_q) & ~inhibit & push_ok;
    reject_d = qual_evt & ~push;
  end

  // Front-end state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      state_q  <= IDLE;
      lat_q    <= '0;
      deb_q    <= '0;
      jcnt_q   <= '0;
      reject_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      state_q  <= state_d;
      lat_q    <= lat_d;
      deb_q    <= deb_d;
      jcnt_q   <= jcnt_d;
      reject_q <= reject_d;
    end
  end

  coin_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (pat_to_code(lat_q)),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign coin_valid   = ~fifo_empty;
  assign coin_out     = coin_valid ? fifo_head : COIN_NONE;
  assign reject_pulse = reject_q;
  assign jam          = (state_q == JAM);

`ifdef COIN_STATS_EN
  logic [15:0] acc_q, acc_d, rej_q, rej_d;

  // Saturating event counters.
  always_comb begin
    acc_d = acc_q;
    rej_d = rej_q;
    if (push && acc_q != 16'hFFFF)     acc_d = acc_q + 16'd1;
    if (reject_d && rej_q != 16'hFFFF) rej_d = rej_q + 16'd1;
  end

  // Counter registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      rej_q <= '0;
    end else begin
      acc_q <= acc_d;
      rej_q <= rej_d;
    end
  end

  assign accepted_count = acc_q;
  assign rejected_count = rej_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor (DEBOUNCE=4, JAM=16, DEPTH=4) with a
// run-length behavioural model checked every cycle, plus literal expectations.
module tb_coin_acceptor;

  localparam int DEB   = 4;
  localparam int JAMC  = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] sense = 3'b000;
  logic       inhibit = 1'b0;
  logic       coin_ready = 1'b0;
  logic [1:0] coin_out;
  logic       coin_valid, reject_pulse, jam, fifo_full;
`ifdef COIN_STATS_EN
  logic [15:0] accepted_count, rejected_count;
`endif

  always #5 clk = ~clk;

  coin_acceptor #(
    .DEBOUNCE_CYCLES (DEB),
    .JAM_CYCLES      (JAMC),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sense_25       (sense[0]),
    .sense_50       (sense[1]),
    .sense_100      (sense[2]),
    .inhibit        (inhibit),
    .coin_out       (coin_out),
    .coin_valid     (coin_valid),
    .coin_ready     (coin_ready),
    .reject_pulse   (reject_pulse),
    .jam            (jam),
    .fifo_full      (fifo_full)
`ifdef COIN_STATS_EN
    ,
    .accepted_count (accepted_count),
    .rejected_count (rejected_count)
`endif
  );

  // ---------------- behavioural model ----------------
  int         cyc = 0;
  bit         m_started = 0;
  logic [2:0] p1 = 0, p2 = 0, mpat, run_pat = 0;
  int         run = 0, since = 0, zero_run = 0;
  bit         done = 0, jam_m = 0, m_rej = 0, evt, accept, mpop;
  int         m_acc = 0, m_rejc = 0;
  logic [1:0] exp_q[$];

  function automatic logic [1:0] code_of(input logic [2:0] p);
    if (p == 3'b001) return 2'b00;
    if (p == 3'b010) return 2'b01;
    return 2'b10;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      m_started = 1;
      p1 = 0; p2 = 0; run = 0; run_pat = 0; done = 0; since = 0;
      jam_m = 0; zero_run = 0; m_rej = 0; m_acc = 0; m_rejc = 0;
      exp_q.delete();
    end else begin
      mpat = p2;
      p2 = p1;
      p1 = sense;
      mpop = (exp_q.size() != 0) && coin_ready;
      evt = 0;
      if (jam_m) begin
        // jammed: need DEB consecutive quiet cycles to recover
        if (mpat == 0) begin
          zero_run++;
          if (zero_run == DEB) begin
            jam_m = 0; done = 0; run = 0;
          end
        end else zero_run = 0;
      end else if (done) begin
        // coin already qualified: wait for release, count held cycles
        if (mpat == 0) begin
          done = 0; run = 0;
        end else begin
          since++;
          if (since == JAMC) begin
            jam_m = 1; zero_run = 0;
          end
        end
      end else begin
        // a pattern held unchanged for DEB+1 sampled cycles qualifies
        if (mpat == 0) run = 0;
        else if (run > 0 && mpat == run_pat) run++;
        else begin
          run = 1; run_pat = mpat;
        end
        if (run == DEB + 1) begin
          evt = 1; done = 1; since = 1;
        end
      end
      accept = evt && ($countones(run_pat) == 1) && !inhibit &&
               ((exp_q.size() < DEPTH) || mpop);
      m_rej = evt && !accept;
      if (mpop) void'(exp_q.pop_front());
      if (accept) exp_q.push_back(code_of(run_pat));
      if (accept && m_acc < 65535) m_acc++;
      if (m_rej && m_rejc < 65535) m_rejc++;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0, n_errs = 0;
  int n_valid = 0, n_rej = 0, n_pop = 0;
  int valid_rise = -1, jam_rise = -1, jam_fall = -1, last_pop = -1;
  logic [1:0] rise_code = 2'b11;
  bit valid_prev = 0, jam_prev = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic compare();
    if (!m_started) return;
    chk("coin_valid", coin_valid, exp_q.size() != 0);
    chk("coin_out", coin_out, (exp_q.size() != 0) ? exp_q[0] : 2'b11);
    chk("reject_pulse", reject_pulse, m_rej);
    chk("jam", jam, jam_m);
    chk("fifo_full", fifo_full, exp_q.size() == DEPTH);
`ifdef COIN_STATS_EN
    chk("accepted_count", accepted_count, m_acc);
    chk("rejected_count", rejected_count, m_rejc);
`endif
    if (coin_valid === 1'b1) begin
      n_valid++;
      if (!valid_prev) begin
        valid_rise = cyc;
        rise_code = coin_out;
      end
      if (coin_ready) begin
        n_pop++;
        last_pop = cyc;
      end
    end
    if (reject_pulse === 1'b1) n_rej++;
    if (jam === 1'b1 && !jam_prev) jam_rise = cyc;
    if (jam === 1'b0 && jam_prev) jam_fall = cyc;
    valid_prev = (coin_valid === 1'b1);
    jam_prev = (jam === 1'b1);
  endtask

  // Each step checks at the falling edge, then returns 2 time units after
  // the next rising edge where inputs are changed.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compare();
      @(posedge clk);
      #2;
    end
  endtask

  int s, r, v0, j0, p0;

  task automatic coin(input logic [2:0] p, input int hold, input int gap);
    sense = p;
    s = cyc;
    step(hold);
    sense = 3'b000;
    step(gap);
  endtask

  initial begin
    @(posedge clk);
    #2;
    // reset values
    chk("rst_coin_out", coin_out, 2'b11);
    chk("rst_coin_valid", coin_valid, 1'b0);
    chk("rst_reject", reject_pulse, 1'b0);
    chk("rst_jam", jam, 1'b0);
    chk("rst_fifo_full", fifo_full, 1'b0);
    step(1);
    reset = 1'b0;
    step(2);

    // clean 50 coin, drained immediately
    coin_ready = 1'b1;
    v0 = n_valid; j0 = n_rej;
    coin(3'b010, 10, 8);
    chk("c50_latency", valid_rise - s, 7);
    chk("c50_code", rise_code, 2'b01);
    chk("c50_valid_cycles", n_valid - v0, 1);
    chk("c50_no_reject", n_rej - j0, 0);

    // short glitch on 25
    v0 = n_valid; j0 = n_rej;
    coin(3'b001, 3, 8);
    chk("glitch_no_push", n_valid - v0, 0);
    chk("glitch_no_reject", n_rej - j0, 0);

    // two sensors at once
    v0 = n_valid; j0 = n_rej;
    coin(3'b101, 8, 8);
    chk("multi_reject", n_rej - j0, 1);
    chk("multi_no_push", n_valid - v0, 0);

    // fill the queue with 100 coins, overflow the fifth
    coin_ready = 1'b0;
    j0 = n_rej; p0 = n_pop;
    for (int i = 0; i < 5; i++) coin(3'b100, 8, 4);
    chk("fill_full", fifo_full, 1'b1);
    chk("fill_head", coin_out, 2'b10);
    chk("fill_reject", n_rej - j0, 1);
    r = cyc;
    coin_ready = 1'b1;
    step(6);
    chk("drain_pops", n_pop - p0, 4);
    chk("drain_last_pop", last_pop - r, 3);
    chk("drain_empty_out", coin_out, 2'b11);

    // held sensor jams, then recovers
    v0 = n_valid; j0 = n_rej;
    coin(3'b010, 40, 12);
    chk("jam_coin_once", n_valid - v0, 1);
    chk("jam_rise", jam_rise - s, 22);
    chk("jam_fall", jam_fall - s, 46);
    chk("jam_no_reject", n_rej - j0, 0);
    v0 = n_valid;
    coin(3'b001, 8, 8);
    chk("after_jam_25", n_valid - v0, 1);
    chk("after_jam_code", rise_code, 2'b00);

    // reset while a coin is held: requalified after reset
    v0 = n_valid;
    sense = 3'b010;
    s = cyc;
    step(5);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(15);
    sense = 3'b000;
    step(8);
    chk("rst_mid_once", n_valid - v0, 1);
    chk("rst_mid_latency", valid_rise - s, 13);

    // inhibited coin from a fresh reset
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(2);
    v0 = n_valid; j0 = n_rej;
    inhibit = 1'b1;
    coin(3'b001, 8, 8);
    inhibit = 1'b0;
    chk("inhibit_reject", n_rej - j0, 1);
    chk("inhibit_no_push", n_valid - v0, 0);
`ifdef COIN_STATS_EN
    chk("stats_rejected", rejected_count, 16'd1);
    chk("stats_accepted", accepted_count, 16'd0);
`endif
    step(2);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
